// File: rtl/ritc_bitslip_sequencer.sv
// Walks all 72 RITC channel/bit lanes, bitslipping each until the training pattern is seen.
// Optional RITC_ALIGN_FAILMAP_EN adds a per-lane failure map output.
module ritc_bitslip_sequencer #(
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_SLIP      = 8
) (
    input  logic        user_clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [7:0]  pattern_i,
    output logic        dp_sel_o,
    output logic        dp_wr_o,
    output logic [3:0]  dp_addr_o,
    output logic [31:0] dp_dat_o,
    input  logic [31:0] dp_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fail_o,
    output logic [6:0]  first_fail_o
`ifdef RITC_ALIGN_FAILMAP_EN
    ,
    output logic [71:0] fail_map_o
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] SLIP   = 3'd5;
    localparam logic [2:0] NEXT   = 3'd6;
    localparam logic [2:0] FINISH = 3'd7;

    localparam logic [9:0] SETTLE_LOAD_C = 10'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MAX_SLIP_C    = 4'(MAX_SLIP);
    localparam logic [3:0] DP_ADDR_C     = 4'd2;

    logic [2:0]  state_r, fsm_next_s, next_state_s;
    logic [7:0]  pattern_r;
    logic [3:0]  slip_cnt_r;
    logic [9:0]  settle_cnt_r;
    logic [2:0]  ch_r, adv_ch_s;
    logic [3:0]  bit_r, adv_bit_s;
    logic [6:0]  sel_next_s;
    logic        match_s, last_bit_s, fail_mark_s;
    logic        dp_sel_r, dp_wr_r, busy_r, done_r, fail_r;
    logic [3:0]  dp_addr_r;
    logic [31:0] dp_dat_r;
    logic [6:0]  first_fail_r;
    logic        unused_dat_s;

    assign unused_dat_s = ^dp_dat_i[31:8];

    // Datapath control word: [31] training disable, [30] bitslip, [22:16] lane select.
    function automatic logic [31:0] bus_word(input logic dis, input logic slip, input logic [6:0] sel);
        bus_word = {dis, slip, 7'd0, sel, 16'd0};
    endfunction

    // Lane-index arithmetic: bits 0..11 within a channel, then the next channel.
    always_comb begin
        match_s    = (dp_dat_i[7:0] == pattern_r);
        last_bit_s = (ch_r == 3'd5) && (bit_r == 4'd11);
        if (bit_r == 4'd11) begin
            adv_bit_s = 4'd0;
            adv_ch_s  = ch_r + 3'd1;
        end else begin
            adv_bit_s = bit_r + 4'd1;
            adv_ch_s  = ch_r;
        end
        if (state_r == IDLE) begin
            sel_next_s = 7'd0;
        end else begin
            sel_next_s = {adv_ch_s, adv_bit_s};
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            IDLE:    fsm_next_s = (start_i && !abort_i) ? SELECT : IDLE;
            SELECT:  fsm_next_s = SETTLE;
            SETTLE:  fsm_next_s = (settle_cnt_r == 10'd0) ? SAMPLE : SETTLE;
            SAMPLE:  fsm_next_s = CHECK;
            CHECK: begin
                if (match_s) begin
                    fsm_next_s = NEXT;
                end else if (slip_cnt_r < MAX_SLIP_C) begin
                    fsm_next_s = SLIP;
                end else begin
                    fsm_next_s = NEXT;
                end
            end
            SLIP:    fsm_next_s = SETTLE;
            NEXT:    fsm_next_s = last_bit_s ? FINISH : SELECT;
            FINISH:  fsm_next_s = IDLE;
            default: fsm_next_s = IDLE;
        endcase
        next_state_s = (abort_i && (state_r != IDLE)) ? IDLE : fsm_next_s;
        fail_mark_s  = (state_r == CHECK) && (next_state_s == NEXT) && !match_s;
    end

    // FSM state, counters, lane index and failure tracking.
    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            pattern_r    <= 8'd0;
            slip_cnt_r   <= 4'd0;
            settle_cnt_r <= 10'd0;
            ch_r         <= 3'd0;
            bit_r        <= 4'd0;
            fail_r       <= 1'b0;
            first_fail_r <= 7'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == IDLE && next_state_s == SELECT) begin
                pattern_r    <= pattern_i;
                slip_cnt_r   <= 4'd0;
                ch_r         <= 3'd0;
                bit_r        <= 4'd0;
                fail_r       <= 1'b0;
                first_fail_r <= 7'd0;
            end
            if (next_state_s == SETTLE && state_r != SETTLE) begin
                settle_cnt_r <= SETTLE_LOAD_C;
            end else if (state_r == SETTLE && settle_cnt_r != 10'd0) begin
                settle_cnt_r <= settle_cnt_r - 10'd1;
            end
            if (state_r == SLIP && next_state_s == SETTLE && slip_cnt_r != 4'hF) begin
                slip_cnt_r <= slip_cnt_r + 4'd1;
            end
            if (state_r == NEXT && next_state_s != IDLE) begin
                slip_cnt_r <= 4'd0;
                if (next_state_s == SELECT) begin
                    ch_r  <= adv_ch_s;
                    bit_r <= adv_bit_s;
                end
            end
            if (fail_mark_s) begin
                fail_r <= 1'b1;
                if (!fail_r) begin
                    first_fail_r <= {ch_r, bit_r};
                end
            end
        end
    end

    // Registered bus and status outputs, decoded from the upcoming state.
    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            dp_sel_r  <= 1'b0;
            dp_wr_r   <= 1'b0;
            dp_addr_r <= 4'd0;
            dp_dat_r  <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (next_state_s == FINISH);
            dp_addr_r <= (next_state_s != IDLE) ? DP_ADDR_C : 4'd0;
            case (next_state_s)
                SELECT: begin
                    dp_sel_r <= 1'b1;
                    dp_wr_r  <= 1'b1;
                    dp_dat_r <= bus_word(1'b0, 1'b0, sel_next_s);
                end
                SLIP: begin
                    dp_sel_r <= 1'b1;
                    dp_wr_r  <= 1'b1;
                    dp_dat_r <= bus_word(1'b0, 1'b1, {ch_r, bit_r});
                end
                FINISH: begin
                    dp_sel_r <= 1'b1;
                    dp_wr_r  <= 1'b1;
                    dp_dat_r <= bus_word(1'b1, 1'b0, {ch_r, bit_r});
                end
                default: begin
                    dp_sel_r <= 1'b0;
                    dp_wr_r  <= 1'b0;
                    dp_dat_r <= 32'd0;
                end
            endcase
        end
    end

`ifdef RITC_ALIGN_FAILMAP_EN
    logic [71:0] fail_map_r;
    logic [6:0]  fail_idx_s;

    assign fail_idx_s = ({4'd0, ch_r} * 7'd12) + {3'd0, bit_r};

    // Per-lane failure map, indexed ch*12+bit; held after done or abort.
    always_ff @(posedge user_clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_map_r <= 72'd0;
        end else if (state_r == IDLE && next_state_s == SELECT) begin
            fail_map_r <= 72'd0;
        end else if (fail_mark_s) begin
            fail_map_r[fail_idx_s] <= 1'b1;
        end
    end

    assign fail_map_o = fail_map_r;
`endif

    assign dp_sel_o     = dp_sel_r;
    assign dp_wr_o      = dp_wr_r;
    assign dp_addr_o    = dp_addr_r;
    assign dp_dat_o     = dp_dat_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign fail_o       = fail_r;
    assign first_fail_o = first_fail_r;

endmodule

// File: tb/tb_ritc_bitslip_sequencer.sv
// Directed bench for ritc_bitslip_sequencer with a behavioural datapath model.
module tb_ritc_bitslip_sequencer;

    localparam int SETTLE = 4;
    localparam int PASS_CYC = 72 * (SETTLE + 4) + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  pattern = 8'd0;
    logic        dp_sel_o, dp_wr_o, busy_o, done_o, fail_o;
    logic [3:0]  dp_addr_o;
    logic [31:0] dp_dat_o, dp_dat_i;
    logic [6:0]  first_fail_o;
`ifdef RITC_ALIGN_FAILMAP_EN
    logic [71:0] fail_map_o;
    logic [71:0] exp_map;
`endif

    int total = 0;
    int bad = 0;
    int mode = 0;
    int wr_cnt = 0, slip_wr_cnt = 0, slip27_cnt = 0, done_cnt = 0, busy_cycles = 0, bad_addr_cnt = 0;
    logic [6:0]  cur_sel = 7'd0;
    logic [31:0] last_wr = 32'd0;

    ritc_bitslip_sequencer #(.SETTLE_CYCLES(SETTLE), .MAX_SLIP(8)) dut (
        .user_clk_i   (clk),
        .rst_i        (rst),
        .start_i      (start),
        .abort_i      (abort),
        .pattern_i    (pattern),
        .dp_sel_o     (dp_sel_o),
        .dp_wr_o      (dp_wr_o),
        .dp_addr_o    (dp_addr_o),
        .dp_dat_o     (dp_dat_o),
        .dp_dat_i     (dp_dat_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fail_o       (fail_o),
        .first_fail_o (first_fail_o)
`ifdef RITC_ALIGN_FAILMAP_EN
        ,
        .fail_map_o   (fail_map_o)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: mode 0 always aligned; mode 1 lane 0x27 needs 3 slips, 0x40/0x5B never align.
    always_comb begin
        dp_dat_i = 32'd0;
        if (dp_addr_o == 4'd2) begin
            if (mode == 0) dp_dat_i = 32'h0000_00A5;
            else if (cur_sel == 7'h40 || cur_sel == 7'h5B) dp_dat_i = 32'h0000_003C;
            else if (cur_sel == 7'h27 && slip27_cnt < 3) dp_dat_i = 32'h0000_0000;
            else dp_dat_i = 32'h0000_00A5;
        end
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy_o) busy_cycles++;
        if (done_o) done_cnt++;
        if (dp_sel_o && dp_wr_o) begin
            wr_cnt++;
            last_wr = dp_dat_o;
            if (dp_addr_o != 4'd2) bad_addr_cnt++;
            if (!dp_dat_o[31]) cur_sel = dp_dat_o[22:16];
            if (dp_dat_o[30]) begin
                slip_wr_cnt++;
                if (dp_dat_o[22:16] == 7'h27) slip27_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        wr_cnt = 0; slip_wr_cnt = 0; slip27_cnt = 0; done_cnt = 0;
        busy_cycles = 0; bad_addr_cnt = 0; cur_sel = 7'd0;
    endtask

    task automatic do_start(input logic [7:0] p);
        pattern = p;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if ({dp_sel_o, dp_wr_o, dp_addr_o, dp_dat_o} !== 38'd0) begin bad++; $display("FAIL reset_bus got=%h want=0", {dp_sel_o, dp_wr_o, dp_addr_o, dp_dat_o}); end
        total++; if ({busy_o, done_o, fail_o} !== 3'b000) begin bad++; $display("FAIL reset_status got=%b want=000", {busy_o, done_o, fail_o}); end
        total++; if (first_fail_o !== 7'd0) begin bad++; $display("FAIL reset_first_fail got=%h want=0", first_fail_o); end
        rst = 1'b0;
        tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy_o); end
    endtask

    task automatic test_start_abort_idle();
        clear_counts();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (5) tick();
        total++; if (busy_o !== 1'b0 || wr_cnt != 0) begin bad++; $display("FAIL start_with_abort busy=%b writes=%0d want busy=0 writes=0", busy_o, wr_cnt); end
    endtask

    task automatic test_clean_pass();
        bit ok;
        clear_counts();
        mode = 0;
        do_start(8'hA5);
        wait_idle(3000, ok);
        total++; if (!ok) begin bad++; $display("FAIL clean_timeout got=no_done want=done"); end
        total++; if (wr_cnt != 73) begin bad++; $display("FAIL clean_writes got=%0d want=73", wr_cnt); end
        total++; if (slip_wr_cnt != 0) begin bad++; $display("FAIL clean_slips got=%0d want=0", slip_wr_cnt); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL clean_done got=%0d want=1", done_cnt); end
        total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL clean_fail got=%b want=0", fail_o); end
        total++; if (busy_cycles + 1 < PASS_CYC - 2 || busy_cycles + 1 > PASS_CYC + 2) begin bad++; $display("FAIL clean_cycles got=%0d want=%0d+-2", busy_cycles + 1, PASS_CYC); end
        total++; if (last_wr !== 32'h805B_0000) begin bad++; $display("FAIL clean_final_word got=%h want=805b0000", last_wr); end
        total++; if (bad_addr_cnt != 0) begin bad++; $display("FAIL clean_addr got=%0d bad writes want=0", bad_addr_cnt); end
    endtask

    task automatic test_slip_fail();
        bit ok;
        clear_counts();
        mode = 1;
        do_start(8'hA5);
        wait_idle(4000, ok);
        total++; if (!ok) begin bad++; $display("FAIL slip_timeout got=no_done want=done"); end
        total++; if (slip27_cnt != 3) begin bad++; $display("FAIL slip27_count got=%0d want=3", slip27_cnt); end
        total++; if (slip_wr_cnt != 19) begin bad++; $display("FAIL slip_total got=%0d want=19", slip_wr_cnt); end
        total++; if (wr_cnt != 92) begin bad++; $display("FAIL slip_writes got=%0d want=92", wr_cnt); end
        total++; if (fail_o !== 1'b1) begin bad++; $display("FAIL slip_fail got=%b want=1", fail_o); end
        total++; if (first_fail_o !== 7'h40) begin bad++; $display("FAIL slip_first_fail got=%h want=40", first_fail_o); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL slip_done got=%0d want=1", done_cnt); end
        total++; if (last_wr !== 32'h805B_0000) begin bad++; $display("FAIL slip_final_word got=%h want=805b0000", last_wr); end
`ifdef RITC_ALIGN_FAILMAP_EN
        exp_map = 72'd0;
        exp_map[48] = 1'b1;
        exp_map[71] = 1'b1;
        total++; if (fail_map_o !== exp_map) begin bad++; $display("FAIL slip_fail_map got=%h want=%h", fail_map_o, exp_map); end
`endif
    endtask

    task automatic test_abort();
        bit ok;
        bit seen;
        int w;
        clear_counts();
        mode = 0;
        do_start(8'hA5);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (dp_wr_o && !dp_dat_o[31] && dp_dat_o[22:16] == 7'h26) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL abort_reach_bit30 got=not_seen want=seen"); end
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_o); end
        w = wr_cnt;
        repeat (20) tick();
        total++; if (wr_cnt != w) begin bad++; $display("FAIL abort_writes got=%0d want=%0d", wr_cnt, w); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
        total++; if (fail_o !== 1'b0 || first_fail_o !== 7'd0) begin bad++; $display("FAIL abort_fail_hold got=%b/%h want=0/00", fail_o, first_fail_o); end
        clear_counts();
        do_start(8'hA5);
        wait_idle(3000, ok);
        total++; if (!ok || wr_cnt != 73 || done_cnt != 1) begin bad++; $display("FAIL abort_rerun got ok=%0d writes=%0d done=%0d want 1/73/1", ok, wr_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid_slip();
        bit seen;
        clear_counts();
        mode = 1;
        do_start(8'hA5);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dp_wr_o && dp_dat_o[30]) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_reach_slip got=not_seen want=seen"); end
        #1 rst = 1'b1;
        #1;
        total++; if ({dp_sel_o, dp_wr_o, dp_addr_o, dp_dat_o} !== 38'd0) begin bad++; $display("FAIL rst_async_bus got=%h want=0", {dp_sel_o, dp_wr_o, dp_addr_o, dp_dat_o}); end
        total++; if ({busy_o, done_o, fail_o, first_fail_o} !== 10'd0) begin bad++; $display("FAIL rst_async_status got=%h want=0", {busy_o, done_o, fail_o, first_fail_o}); end
        tick();
        tick();
        total++; if ({dp_sel_o, dp_wr_o, dp_addr_o, dp_dat_o} !== 38'd0) begin bad++; $display("FAIL rst_hold_bus got=%h want=0", {dp_sel_o, dp_wr_o, dp_addr_o, dp_dat_o}); end
        rst = 1'b0;
        repeat (3) tick();
        total++; if (busy_o !== 1'b0 || done_cnt != 0) begin bad++; $display("FAIL rst_after busy=%b done=%0d want 0/0", busy_o, done_cnt); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_counts();
        mode = 0;
        do_start(8'hA5);
        repeat (30) tick();
        do_start(8'h00);
        repeat (100) tick();
        do_start(8'h00);
        wait_idle(3000, ok);
        total++; if (!ok || wr_cnt != 73 || done_cnt != 1) begin bad++; $display("FAIL busy_start_ignored got ok=%0d writes=%0d done=%0d want 1/73/1", ok, wr_cnt, done_cnt); end
        total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL busy_start_pattern got fail=%b want=0", fail_o); end
        clear_counts();
        do_start(8'hA5);
        wait_idle(3000, ok);
        total++; if (!ok || wr_cnt != 73 || last_wr !== 32'h805B_0000) begin bad++; $display("FAIL back_to_back got ok=%0d writes=%0d last=%h want 1/73/805b0000", ok, wr_cnt, last_wr); end
    endtask

    initial begin
        test_reset();
        test_start_abort_idle();
        test_clean_pass();
        test_slip_fail();
        test_abort();
        test_reset_mid_slip();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
